// File: rtl/fifo_serial_reader_pkg.sv
// fifo_serial_reader_pkg: constants shared by the FIFO read-side consumer and the FIFO itself
package fifo_pkg;
    localparam int FIFO_WIDTH = 4;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;
endpackage

// File: rtl/fifo_serial_reader_if.sv
// fifo_serial_reader_if: FIFO head and bit-serial link signals of the read-side consumer
interface fifo_serial_reader_if #(parameter int WIDTH = fifo_pkg::FIFO_WIDTH);
    logic [WIDTH-1:0] fifo_data;
    logic fifo_empty_n;
    logic fifo_shift_out;
    logic tx_bit;
    logic tx_valid;
    logic tx_last;
    logic tx_ready;
    modport master (
        input  fifo_data, fifo_empty_n, tx_ready,
        output fifo_shift_out, tx_bit, tx_valid, tx_last
    );
    modport slave (
        output fifo_data, fifo_empty_n, tx_ready,
        input  fifo_shift_out, tx_bit, tx_valid, tx_last
    );
endinterface

// File: rtl/fifo_serial_reader_shreg.sv
// serial_shreg: load/shift-right register with a bit counter flagging the word's last bit
module serial_shreg #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             res,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             q,
    output logic             last
);
    localparam int BW = $clog2(WIDTH);
    logic [WIDTH-1:0] shreg;
    logic [BW-1:0] bitcnt;
    assign q = shreg[0];
    assign last = bitcnt == BW'(WIDTH - 1);
    always_ff @(posedge clk) begin
        if (res) begin
            shreg <= '0;
            bitcnt <= '0;
        end else if (load) begin
            shreg <= din;
            bitcnt <= '0;
        end else if (shift) begin
            shreg <= shreg >> 1;
            bitcnt <= bitcnt + 1'b1;
        end
    end
endmodule

// File: rtl/fifo_serial_reader.sv
// fifo_serial_reader: pops FIFO words and sends them LSB-first over a valid/ready bit-serial link,
// with an idle gap after each word and a wrapping count of completed words
module fifo_serial_reader
    import fifo_pkg::*;
#(
    parameter int WIDTH      = FIFO_WIDTH,
    parameter int GAP_CYCLES = 1,
    parameter int CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 res,
    input  logic                 en,
    fifo_serial_reader_if.master bus,
    output logic                 busy,
    output logic [CNT_W-1:0]     words_sent
);
    localparam int GW = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;
    logic [1:0] state;
    logic [GW-1:0] gapcnt;
    logic pop, accept, last, q;
    // pop is Mealy so the FIFO advances on the same edge the word is captured
    assign pop = (state == ST_IDLE) && en && bus.fifo_empty_n;
    assign accept = bus.tx_valid && bus.tx_ready;
    assign bus.fifo_shift_out = pop;
    assign bus.tx_valid = state == ST_SHIFT;
    assign bus.tx_bit = bus.tx_valid && q;
    assign bus.tx_last = bus.tx_valid && last;
    assign busy = state != ST_IDLE;
    serial_shreg #(.WIDTH(WIDTH)) u_shreg (
        .clk   (clk),
        .res   (res),
        .load  (pop),
        .shift (accept),
        .din   (bus.fifo_data),
        .q     (q),
        .last  (last)
    );
    always_ff @(posedge clk) begin
        if (res) begin
            state <= ST_IDLE;
            gapcnt <= '0;
            words_sent <= '0;
        end else begin
            case (state)
                ST_IDLE: if (pop) state <= ST_SHIFT;
                ST_SHIFT: if (accept && last) begin
                    words_sent <= words_sent + 1'b1;
                    state <= GAP_CYCLES > 0 ? ST_GAP : ST_IDLE;
                    gapcnt <= GW'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);
                end
                ST_GAP: begin
                    gapcnt <= gapcnt - 1'b1;
                    if (gapcnt == '0) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_serial_reader.sv
// tb_fifo_serial_reader: directed checks of pop, serialization, backpressure, gap, en/empty, reset and wrap
module tb_fifo_serial_reader;
    import fifo_pkg::*;
    logic clk = 0;
    logic res = 1;
    logic en_a = 0;
    logic en_b = 0;
    logic busy_a, busy_b;
    logic [15:0] ws_a;
    logic [1:0] ws_b;
    int tests = 0;
    int fails = 0;
    fifo_serial_reader_if #(.WIDTH(4)) a_if ();
    fifo_serial_reader_if #(.WIDTH(4)) b_if ();
    fifo_serial_reader #(.WIDTH(4), .GAP_CYCLES(1), .CNT_W(16)) u_a (
        .clk(clk), .res(res), .en(en_a), .bus(a_if.master), .busy(busy_a), .words_sent(ws_a)
    );
    fifo_serial_reader #(.WIDTH(4), .GAP_CYCLES(2), .CNT_W(2)) u_b (
        .clk(clk), .res(res), .en(en_b), .bus(b_if.master), .busy(busy_b), .words_sent(ws_b)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    // one word on instance A: pop, then n cycles of the given ready pattern, then gap and idle
    task automatic run_a(input logic [3:0] w, input int n, input logic [15:0] rdy, input logic [15:0] ws_exp);
        int cnt = 0;
        @(negedge clk);
        en_a = 1;
        a_if.fifo_data = w;
        a_if.fifo_empty_n = 1;
        #1;
        check("pop", a_if.fifo_shift_out, 1);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            a_if.fifo_empty_n = 0;
            a_if.tx_ready = rdy[i];
            #1;
            if (i == 0) check("pop_pulse", a_if.fifo_shift_out, 0);
            check("valid", a_if.tx_valid, 1);
            check("bit", a_if.tx_bit, w[cnt[1:0]]);
            check("last", a_if.tx_last, cnt == 3);
            if (rdy[i]) cnt++;
        end
        check("accepts", cnt, 4);
        @(negedge clk);
        a_if.tx_ready = 0;
        #1;
        check("gap_valid", a_if.tx_valid, 0);
        check("gap_busy", busy_a, 1);
        check("words", ws_a, ws_exp);
        @(negedge clk);
        #1;
        check("idle_busy", busy_a, 0);
    endtask
    initial begin
        int pops, valids, k, pop1, pop2, nbits, first_bit, j;
        logic [7:0] bits;
        logic [3:0] words [2];
        logic [1:0] last_ws;
        logic [1:0] exp_ws [5];
        a_if.fifo_data = 0; a_if.fifo_empty_n = 0; a_if.tx_ready = 0;
        b_if.fifo_data = 0; b_if.fifo_empty_n = 0; b_if.tx_ready = 0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_valid", a_if.tx_valid, 0);
        check("rst_bit", a_if.tx_bit, 0);
        check("rst_last", a_if.tx_last, 0);
        check("rst_pop", a_if.fifo_shift_out, 0);
        check("rst_busy", busy_a, 0);
        check("rst_words", ws_a, 0);
        res = 0;
        run_a(4'b1011, 4, 16'b1111, 1);
        run_a(4'b1011, 7, 16'b1011001, 2);
        // en low with data waiting: nothing happens
        en_a = 0;
        a_if.fifo_data = 4'h7;
        a_if.fifo_empty_n = 1;
        pops = 0;
        repeat (10) begin
            @(negedge clk);
            #1;
            pops += int'(a_if.fifo_shift_out) + int'(busy_a);
        end
        check("en0_nopop", pops, 0);
        en_a = 1;
        a_if.fifo_empty_n = 0;
        pops = 0;
        repeat (5) begin
            @(negedge clk);
            #1;
            pops += int'(a_if.fifo_shift_out) + int'(busy_a);
        end
        check("empty_idle", pops, 0);
        // en dropped during bit 2 while the FIFO shows another word
        @(negedge clk);
        a_if.fifo_data = 4'h6;
        a_if.fifo_empty_n = 1;
        a_if.tx_ready = 1;
        #1;
        check("en_pop", a_if.fifo_shift_out, 1);
        @(negedge clk);
        a_if.fifo_data = 4'h9;
        @(negedge clk);
        en_a = 0;
        pops = 0;
        valids = 0;
        repeat (12) begin
            @(negedge clk);
            #1;
            pops += int'(a_if.fifo_shift_out);
            valids += int'(a_if.tx_valid);
        end
        check("endrop_nopop", pops, 0);
        check("endrop_finish", valids, 2);
        check("endrop_words", ws_a, 3);
        a_if.fifo_empty_n = 0;
        a_if.tx_ready = 0;
        // gap and back-to-back on B
        words[0] = 4'h5;
        words[1] = 4'hA;
        en_b = 1;
        b_if.tx_ready = 1;
        k = 0; pop1 = -1; pop2 = -1; nbits = 0; first_bit = -1; bits = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            b_if.fifo_empty_n = k < 2;
            b_if.fifo_data = words[k < 2 ? k : 1];
            #1;
            if (b_if.fifo_shift_out) begin
                if (k == 0) pop1 = c; else pop2 = c;
                k++;
            end
            if (b_if.tx_valid && nbits < 8) begin
                if (first_bit < 0) first_bit = c;
                bits[nbits] = b_if.tx_bit;
                nbits++;
            end
        end
        check("b2b_pops", k, 2);
        check("b2b_period", pop2 - pop1, 7);
        check("b2b_latency", first_bit - pop1, 1);
        check("b2b_bits", bits, 8'b1010_0101);
        check("b2b_words", ws_b, 2);
        b_if.fifo_empty_n = 0;
        // reset during bit 2 on A
        @(negedge clk);
        a_if.fifo_data = 4'hC;
        a_if.fifo_empty_n = 1;
        a_if.tx_ready = 1;
        en_a = 1;
        @(negedge clk);
        a_if.fifo_empty_n = 0;
        @(negedge clk);
        @(negedge clk);
        res = 1;
        @(negedge clk);
        #1;
        check("rstmid_valid", a_if.tx_valid, 0);
        check("rstmid_busy", busy_a, 0);
        check("rstmid_words", ws_a, 0);
        res = 0;
        run_a(4'b0110, 4, 16'b1111, 1);
        // counter wrap on B
        exp_ws[0] = 1; exp_ws[1] = 2; exp_ws[2] = 3; exp_ws[3] = 0; exp_ws[4] = 1;
        b_if.fifo_data = 4'h3;
        b_if.fifo_empty_n = 1;
        last_ws = ws_b;
        j = 0;
        for (int c = 0; c < 50 && j < 5; c++) begin
            @(negedge clk);
            #1;
            if (ws_b != last_ws) begin
                check($sformatf("wrap_%0d", j), ws_b, exp_ws[j]);
                last_ws = ws_b;
                j++;
            end
        end
        check("wrap_count", j, 5);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fifo_serial_reader.md
Name: fifo_serial_reader

Overview:
Read-side consumer for the register-based FIFO.
- Pops one WIDTH-bit word at a time from the FIFO head.
- Serializes each word LSB-first onto a bit-serial link with a per-bit valid/ready handshake.
- Inserts a programmable idle gap between words.
- Sits between a FIFO instance and the downstream serial sink; also keeps a count of transmitted words.

Parameters:
- WIDTH, 4, FIFO word width in bits; also the number of serial bits per word (WIDTH >= 2).
- GAP_CYCLES, 1, idle cycles inserted after each word's last bit (0 = back-to-back).
- CNT_W, 16, width of the words_sent counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- res  input  1  synchronous, active-high reset.
- en  input  1  allows new words to be popped; sampled only in IDLE.
- fifo_data  input  WIDTH  FIFO head word; valid while fifo_empty_n=1.
- fifo_empty_n  input  1  FIFO holds at least one word.
- fifo_shift_out  output  1  one-cycle pop strobe to the FIFO.
- tx_bit  output  1  current serial data bit.
- tx_valid  output  1  tx_bit is valid.
- tx_last  output  1  tx_bit is bit WIDTH-1 of the word.
- tx_ready  input  1  sink accepts tx_bit this cycle.
- busy  output  1  state != IDLE.
- words_sent  output  CNT_W  count of fully transmitted words; wraps modulo 2^CNT_W.

Behaviour:
- Reset (res=1 at an edge):
  - state=IDLE, shift register=0, bit counter=0, gap counter=0, words_sent=0.
  - All outputs are 0 in the following cycle.
  - Reset overrides every other input.
- States: IDLE, SHIFT, GAP.
- IDLE:
  - fifo_shift_out = en & fifo_empty_n. This is combinational (Mealy), so the pop and the capture happen on the same edge.
  - When it is 1: shreg<=fifo_data, bitcnt<=0, next state SHIFT.
  - Otherwise stay in IDLE.
  - tx_valid=0.
- SHIFT:
  - Outputs: tx_valid=1, tx_bit=shreg[0], tx_last=(bitcnt==WIDTH-1), fifo_shift_out=0.
  - On tx_valid&tx_ready: shreg<=shreg>>1, bitcnt<=bitcnt+1.
  - If the accepted bit was last: words_sent<=words_sent+1, then next state is GAP with gapcnt<=GAP_CYCLES-1 when GAP_CYCLES>0, otherwise IDLE.
  - tx_ready=0: hold tx_bit, tx_valid and tx_last stable. tx_valid never drops before acceptance.
- GAP:
  - tx_valid=0.
  - gapcnt decrements each cycle; at 0, next state IDLE.
- Latency:
  - Pop edge to first tx_valid: 1 cycle.
  - A word with tx_ready held high takes WIDTH cycles in SHIFT.
  - Minimum period per word is WIDTH+GAP_CYCLES+1 cycles (the +1 is the IDLE pop cycle).
- Boundary conditions:
  - en deasserted mid-word: the current word completes, including its gap; no further pop.
  - FIFO empty in IDLE: no pop; remain IDLE indefinitely.
  - fifo_empty_n toggling outside IDLE: ignored.
  - Reset mid-word: transmission aborts immediately and tx_valid=0 next cycle. The popped word is discarded and not counted.
  - words_sent wraps from 2^CNT_W-1 to 0 with no flag.
  - No pop is issued while a word is in flight, so FIFO data is never overwritten or read twice.

Decomposition:
- Shared package fifo_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_GAP=2'd2;
  - the default WIDTH constant, shared with the FIFO.
- One natural sub-module: serial_shreg (WIDTH-bit load/shift-right register with a bit counter and a last flag).
- FSM, gap counter and words_sent stay in the top module.

Test Plan:
- Pop and serialize. WIDTH=4, GAP=1, en=1, tx_ready=1, FIFO holds 4'b1011.
  - fifo_shift_out pulses 1 cycle.
  - tx_bit sequence 1,1,0,1 on 4 consecutive cycles; tx_last only on the 4th.
  - words_sent=1.
- Backpressure. Same word, tx_ready toggled 1,0,0,1,1,0,1.
  - Each bit is held while ready=0.
  - Exactly 4 acceptances, sequence 1,1,0,1, no duplicates.
- Gap and back-to-back. GAP=2, FIFO holds 4'h5 then 4'hA, tx_ready=1.
  - Bits 1,0,1,0, then 2 idle cycles and 1 pop cycle, then 0,1,0,1.
  - Pops are exactly 7 cycles apart.
- en and empty handling.
  - en=0 with FIFO non-empty: no pop for 10 cycles.
  - FIFO empty with en=1: busy=0.
  - en dropped during bit 2 of a word: the word finishes; no second pop.
- Reset mid-word. res=1 during bit 2.
  - Next cycle: tx_valid=0, busy=0, words_sent=0.
  - After release, the next FIFO word serializes correctly.
- Counter wrap. CNT_W=2, send 5 words: words_sent reads 1,2,3,0,1.
